// File: rtl/button_event_arbiter.sv
// ---------------------------------------------------------------------------
// button_event_arbiter
//
// Debounces WIDTH already-synchronized button/switch inputs, turns debounced
// press edges (and, optionally, release edges) into events, and schedules
// them round-robin onto one valid/ready event channel. Every event source
// owns one pending bit; an edge that lands on a pending bit that is not being
// granted in the same cycle is lost and counted in drop_cnt.
//
// Parameters:
//   WIDTH          number of inputs (1..16)
//   SAMPLE_CNT_MAX clocks per debounce sample tick (>= 2)
//   PULSE_CNT_MAX  consecutive high ticks needed to assert debounced (1..255)
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset; clears all state and outputs
//   sync_in    synchronized inputs (no synchronizer inside)
//   debounced  debounced level per input
//   ev_valid   event available
//   ev_ready   consumer ready
//   ev_id      index of the input that produced the event
//   ev_fall    1 = release event, 0 = press event
//   drop_cnt   saturating count of events lost to overrun
//
// Optional feature macro: BTN_EVENT_FALL_EN
//   defined   : release edges are queued too (slot 2i = press, 2i+1 = release)
//               and round-robin runs over 2*WIDTH slots
//   undefined : press events only, ev_fall tied to 0, no release logic
//
// Handshake: an event transfers on a rising clk edge where ev_valid && ev_ready.
// While ev_valid && !ev_ready, ev_id and ev_fall hold their values and
// ev_valid stays high; ev_valid only drops after a transfer (or on rst).
// ---------------------------------------------------------------------------
module button_event_arbiter #(
    parameter int WIDTH          = 4,
    parameter int SAMPLE_CNT_MAX = 25000,
    parameter int PULSE_CNT_MAX  = 150
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [WIDTH-1:0]                             sync_in,
    output logic [WIDTH-1:0]                             debounced,
    output logic                                         ev_valid,
    input  logic                                         ev_ready,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] ev_id,
    output logic                                         ev_fall,
    output logic [7:0]                                   drop_cnt
);

    localparam int IDW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef BTN_EVENT_FALL_EN
    localparam int NSLOT = 2 * WIDTH;
`else
    localparam int NSLOT = WIDTH;
`endif
    localparam int PW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam int SW = $clog2(SAMPLE_CNT_MAX);

    localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
    localparam logic [7:0]    PULSE_MAX   = 8'(PULSE_CNT_MAX);
    localparam logic [PW-1:0] SLOT_LAST   = PW'(NSLOT - 1);

    logic [SW-1:0]    sample_cnt;
    logic             tick;
    logic [7:0]       cnt [WIDTH];
    logic [WIDTH-1:0] prev;
    logic [NSLOT-1:0] pending;
    logic [NSLOT-1:0] pending_next;
    logic [NSLOT-1:0] slot_edge;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    win;
    logic [PW-1:0]    idx_s;
    logic             found;
    logic             load;
    logic [8:0]       drop_sum;
    logic [7:0]       drop_next;
    int               idx;

    // -----------------------------------------------------------------------
    // Shared sample tick
    // -----------------------------------------------------------------------
    assign tick = (sample_cnt == SAMPLE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (tick) begin
            sample_cnt <= '0;
        end else begin
            sample_cnt <= sample_cnt + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Per-input debounce counters: count high ticks, clear on a low tick
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_in[i]) begin
                    if (cnt[i] < PULSE_MAX) begin
                        cnt[i] <= cnt[i] + 8'd1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        debounced = '0;
        for (int i = 0; i < WIDTH; i++) begin
            debounced[i] = (cnt[i] == PULSE_MAX);
        end
    end

    // -----------------------------------------------------------------------
    // Edge detect into event slots
    // -----------------------------------------------------------------------
    always_comb begin
        slot_edge = '0;
        for (int i = 0; i < WIDTH; i++) begin
`ifdef BTN_EVENT_FALL_EN
            slot_edge[2*i]   = debounced[i] & ~prev[i];
            slot_edge[2*i+1] = ~debounced[i] & prev[i];
`else
            slot_edge[i]     = debounced[i] & ~prev[i];
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Round-robin search: first pending slot at or after rr_ptr, wrapping
    // -----------------------------------------------------------------------
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        idx_s = '0;
        for (int k = 0; k < NSLOT; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NSLOT) begin
                idx = idx - NSLOT;
            end
            idx_s = PW'(idx);
            if (!found && pending[idx_s]) begin
                found = 1'b1;
                win   = idx_s;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pending bookkeeping and overrun counting. The grant clears its bit
    // first, so an edge arriving on the granted slot re-arms it without a drop.
    // -----------------------------------------------------------------------
    always_comb begin
        load         = ~ev_valid | ev_ready;
        pending_next = pending;
        drop_sum     = {1'b0, drop_cnt};
        if (load && found) begin
            pending_next[win] = 1'b0;
        end
        for (int s = 0; s < NSLOT; s++) begin
            if (slot_edge[s]) begin
                if (pending[s] && !(load && found && (win == PW'(s)))) begin
                    drop_sum = drop_sum + 9'd1;
                end
                pending_next[s] = 1'b1;
            end
        end
        drop_next = (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
    end

    // -----------------------------------------------------------------------
    // Output register
    // -----------------------------------------------------------------------
`ifdef BTN_EVENT_FALL_EN
    logic fall_q;
    assign ev_fall = fall_q;
`else
    assign ev_fall = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            prev     <= '0;
            pending  <= '0;
            rr_ptr   <= '0;
            ev_valid <= 1'b0;
            ev_id    <= '0;
            drop_cnt <= '0;
`ifdef BTN_EVENT_FALL_EN
            fall_q   <= 1'b0;
`endif
        end else begin
            prev     <= debounced;
            pending  <= pending_next;
            drop_cnt <= drop_next;
            if (load) begin
                ev_valid <= found;
                if (found) begin
`ifdef BTN_EVENT_FALL_EN
                    ev_id  <= IDW'(win >> 1);
                    fall_q <= win[0];
`else
                    ev_id  <= IDW'(win);
`endif
                    rr_ptr <= (win == SLOT_LAST) ? '0 : win + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_button_event_arbiter
//
// Bench for button_event_arbiter with WIDTH=4, SAMPLE_CNT_MAX=4,
// PULSE_CNT_MAX=3. Works in both builds (BTN_EVENT_FALL_EN defined or not).
// A behavioural model of the event rules runs alongside the DUT every cycle;
// a vector table covers the single-press timing, and hand sequences cover
// bounce, arbitration order, overrun, mid-handshake reset and release events.
// ---------------------------------------------------------------------------
module tb_button_event_arbiter;

    localparam int W   = 4;
    localparam int SCM = 4;
    localparam int PCM = 3;
`ifdef BTN_EVENT_FALL_EN
    localparam int NS  = 2 * W;
`else
    localparam int NS  = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sync_in;
    logic [W-1:0] debounced;
    logic         ev_valid;
    logic         ev_ready;
    logic [1:0]   ev_id;
    logic         ev_fall;
    logic [7:0]   drop_cnt;

    button_event_arbiter #(
        .WIDTH         (W),
        .SAMPLE_CNT_MAX(SCM),
        .PULSE_CNT_MAX (PCM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sync_in  (sync_in),
        .debounced(debounced),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_id    (ev_id),
        .ev_fall  (ev_fall),
        .drop_cnt (drop_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // ---------------- behavioural model ----------------
    int m_n;            // cycles since reset; tick every SCM-th cycle
    int m_cnt  [W];     // consecutive high ticks, capped at PCM
    bit m_prev [W];
    bit m_pend [NS];
    int m_rr;
    bit m_v;
    int m_id;
    bit m_fall;
    int m_drop;

    function automatic void model_reset();
        m_n = 0;
        for (int i = 0; i < W; i++) begin
            m_cnt[i]  = 0;
            m_prev[i] = 0;
        end
        for (int s = 0; s < NS; s++) m_pend[s] = 0;
        m_rr   = 0;
        m_v    = 0;
        m_id   = 0;
        m_fall = 0;
        m_drop = 0;
    endfunction

    function automatic void model_advance(logic [W-1:0] s_in, bit rdy, bit r);
        bit tick;
        bit db [W];
        bit ev [NS];
        bit npend [NS];
        bit load;
        int win;
        if (r) begin
            model_reset();
            return;
        end
        tick = ((m_n % SCM) == SCM - 1);
        for (int i = 0; i < W; i++) db[i] = (m_cnt[i] == PCM);
        for (int s = 0; s < NS; s++) ev[s] = 0;
        for (int i = 0; i < W; i++) begin
`ifdef BTN_EVENT_FALL_EN
            ev[2*i]   = db[i] && !m_prev[i];
            ev[2*i+1] = !db[i] && m_prev[i];
`else
            ev[i]     = db[i] && !m_prev[i];
`endif
        end
        load = !m_v || rdy;
        win  = -1;
        if (load) begin
            for (int k = 0; k < NS; k++) begin
                if (win < 0 && m_pend[(m_rr + k) % NS]) win = (m_rr + k) % NS;
            end
        end
        for (int s = 0; s < NS; s++) npend[s] = m_pend[s];
        if (win >= 0) npend[win] = 0;
        for (int s = 0; s < NS; s++) begin
            if (ev[s]) begin
                if (m_pend[s] && s != win && m_drop < 255) m_drop++;
                npend[s] = 1;
            end
        end
        for (int s = 0; s < NS; s++) m_pend[s] = npend[s];
        if (load) begin
            if (win >= 0) begin
                m_v = 1;
`ifdef BTN_EVENT_FALL_EN
                m_id   = win / 2;
                m_fall = (win % 2) == 1;
`else
                m_id   = win;
                m_fall = 0;
`endif
                m_rr = (win + 1) % NS;
            end else begin
                m_v = 0;
            end
        end
        for (int i = 0; i < W; i++) begin
            m_prev[i] = db[i];
            if (tick) m_cnt[i] = s_in[i] ? ((m_cnt[i] < PCM) ? m_cnt[i] + 1 : PCM) : 0;
        end
        m_n++;
    endfunction

    // ---------------- scoreboard helpers ----------------
    logic [2:0] rec_q [$];   // observed handshakes {fall, id}
    logic [2:0] exp_q [$];   // expected handshakes {fall, id}
    bit seen_db;
    bit seen_v;

    task automatic check_model();
        logic [W-1:0] mdb;
        for (int i = 0; i < W; i++) mdb[i] = (m_cnt[i] == PCM);
        checks++;
        if (debounced !== mdb || ev_valid !== m_v || ev_id !== 2'(m_id) ||
            ev_fall !== m_fall || drop_cnt !== 8'(m_drop)) begin
            failures++;
            $display("FAIL model cyc=%0d got db=%b v=%b id=%0d fall=%b drop=%0d exp db=%b v=%b id=%0d fall=%b drop=%0d",
                     cyc, debounced, ev_valid, ev_id, ev_fall, drop_cnt,
                     mdb, m_v, m_id, m_fall, m_drop);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic check_q(input string name);
        checks++;
        if (rec_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s event count got=%0d exp=%0d", name, rec_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (rec_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL %s event %0d got fall/id=%b exp=%b", name, i, rec_q[i], exp_q[i]);
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    // One clock cycle: compare DUT with the model, drive the inputs that the
    // next rising edge samples, note handshakes, then advance the model.
    task automatic do_cycle(input logic [W-1:0] s, input logic rdy, input logic r);
        @(negedge clk);
        check_model();
        sync_in  = s;
        ev_ready = rdy;
        rst      = r;
        if (!r && ev_valid && rdy) rec_q.push_back({ev_fall, ev_id});
        if (|debounced) seen_db = 1;
        if (ev_valid) seen_v = 1;
        model_advance(s, rdy, r);
        cyc++;
    endtask

    task automatic hold(input logic [W-1:0] s, input logic rdy, input int n);
        for (int i = 0; i < n; i++) do_cycle(s, rdy, 1'b0);
    endtask

    task automatic reset_dut();
        do_cycle('0, 1'b0, 1'b1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0] sync;
        logic         rdy;
        logic [W-1:0] exp_db;
        logic         exp_v;
        logic [1:0]   exp_id;
        logic [7:0]   exp_drop;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [W-1:0] pat;
        int           len;
        int           mode;
        logic         rdy_r;

        // single press on input 2: debounced from cycle 12, one event at 14
        for (int c = 0; c < 16; c++) begin
            tbl[c].sync     = 4'b0100;
            tbl[c].rdy      = 1'b1;
            tbl[c].exp_db   = (c >= 12) ? 4'b0100 : 4'b0000;
            tbl[c].exp_v    = (c == 14);
            tbl[c].exp_id   = (c >= 14) ? 2'd2 : 2'd0;
            tbl[c].exp_drop = 8'd0;
        end

        rst      = 1'b1;
        sync_in  = '0;
        ev_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // ---- single press (table) ----
        reset_dut();
        for (int c = 0; c < 16; c++) begin
            do_cycle(tbl[c].sync, tbl[c].rdy, 1'b0);
            checks++;
            if (debounced !== tbl[c].exp_db || ev_valid !== tbl[c].exp_v ||
                ev_id !== tbl[c].exp_id || ev_fall !== 1'b0 || drop_cnt !== tbl[c].exp_drop) begin
                failures++;
                $display("FAIL table row=%0d got db=%b v=%b id=%0d fall=%b drop=%0d exp db=%b v=%b id=%0d fall=0 drop=%0d",
                         c, debounced, ev_valid, ev_id, ev_fall, drop_cnt,
                         tbl[c].exp_db, tbl[c].exp_v, tbl[c].exp_id, tbl[c].exp_drop);
            end
        end

        // ---- bounce rejection ----
        reset_dut();
        seen_db = 0;
        seen_v  = 0;
        hold(4'b0001, 1'b1, 8);
        hold(4'b0000, 1'b1, 4);
        hold(4'b0001, 1'b1, 8);
        hold(4'b0000, 1'b1, 4);
        check_val("bounce_debounced", 32'(seen_db), 32'd0);
        check_val("bounce_event", 32'(seen_v), 32'd0);
        check_val("bounce_drop", 32'(drop_cnt), 32'd0);

        // ---- arbitration order ----
        reset_dut();
        rec_q.delete();
        hold(4'b1011, 1'b0, 22);
        hold(4'b1011, 1'b1, 4);
        exp_q = '{3'b000, 3'b001, 3'b011};
        check_q("arb_first");
        hold(4'b0000, 1'b1, 8);
        rec_q.delete();
        hold(4'b1001, 1'b1, 20);
`ifdef BTN_EVENT_FALL_EN
        exp_q = '{3'b011, 3'b000};
`else
        exp_q = '{3'b000, 3'b011};
`endif
        check_q("arb_second");

        // ---- overrun: held event plus pending one, third press dropped ----
        reset_dut();
        hold(4'b0010, 1'b0, 16);
        hold(4'b0000, 1'b0, 4);
        hold(4'b0010, 1'b0, 12);
        hold(4'b0000, 1'b0, 4);
        hold(4'b0010, 1'b0, 12);
        hold(4'b0010, 1'b0, 4);
`ifdef BTN_EVENT_FALL_EN
        check_val("overrun_drop", 32'(drop_cnt), 32'd2);
`else
        check_val("overrun_drop", 32'(drop_cnt), 32'd1);
`endif
        check_val("overrun_valid", 32'(ev_valid), 32'd1);
        check_val("overrun_id", 32'(ev_id), 32'd1);
        check_val("overrun_fall", 32'(ev_fall), 32'd0);

        // ---- reset while an event is held ----
        do_cycle(4'b0000, 1'b0, 1'b1);
        rec_q.delete();
        do_cycle(4'b0000, 1'b1, 1'b0);
        check_val("rst_valid", 32'(ev_valid), 32'd0);
        check_val("rst_id", 32'(ev_id), 32'd0);
        check_val("rst_fall", 32'(ev_fall), 32'd0);
        check_val("rst_drop", 32'(drop_cnt), 32'd0);
        check_val("rst_debounced", 32'(debounced), 32'd0);
        seen_v = 0;
        hold(4'b0000, 1'b1, 20);
        check_val("rst_no_replay", 32'(seen_v), 32'd0);

        // ---- press then release input 3 ----
        reset_dut();
        rec_q.delete();
        hold(4'b1000, 1'b1, 16);
        hold(4'b0000, 1'b1, 10);
`ifdef BTN_EVENT_FALL_EN
        exp_q = '{3'b011, 3'b111};
`else
        exp_q = '{3'b011};
`endif
        check_q("press_release");

        // ---- randomized traffic against the model ----
        reset_dut();
        for (int seg = 0; seg < 250; seg++) begin
            pat  = W'($urandom_range(0, 15));
            len  = $urandom_range(1, 24);
            mode = $urandom_range(0, 2);
            for (int c = 0; c < len; c++) begin
                case (mode)
                    0:       rdy_r = 1'b1;
                    1:       rdy_r = ($urandom_range(0, 1) == 1);
                    default: rdy_r = ($urandom_range(0, 7) == 0);
                endcase
                do_cycle(pat, rdy_r, ($urandom_range(0, 399) == 0));
            end
        end
        hold(4'b0000, 1'b1, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
